// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB full-speed receive path.
// Imported by rx_bit_timer and rx_bit_sampler.
package usb_rx_pkg;

    localparam int CLKS_PER_BIT    = 8;
    localparam int SAMPLE_PHASE    = 4;
    localparam int STUFF_LIMIT     = 6;
    localparam int EOP_SE0_SAMPLES = 2;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-timing recovery: resyncs a phase counter on every D+ transition
// and strobes sample_en once per bit period at mid-bit.
// Ports:
//   clk, n_rst   - clock, async active-low reset
//   d_plus_sync  - synchronized D+
//   rcv_en       - low holds the phase counter at 0
//   sample_en    - one-cycle mid-bit sample strobe
module rx_bit_timer
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic rcv_en,
    output logic sample_en
);

    logic       dp_prev;
    logic       dp_edge;
    logic [3:0] count;
    logic [3:0] count_next;

    assign dp_edge = d_plus_sync ^ dp_prev;

    // An edge restarts the bit at phase 1, taking priority over wrap.
    always_comb begin
        count_next = count + 4'd1;
        if (!rcv_en) begin
            count_next = 4'd0;
        end else if (dp_edge) begin
            count_next = 4'd1;
        end else if (count == 4'(CLKS_PER_BIT)) begin
            count_next = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_prev <= 1'b1;
            count   <= 4'd0;
        end else begin
            dp_prev <= d_plus_sync;
            count   <= count_next;
        end
    end

    assign sample_en = rcv_en && (count == 4'(SAMPLE_PHASE));

endmodule

// File: rtl/rx_bit_sampler.sv
// USB FS receive bit decoder: NRZI decode, bit unstuffing,
// LSB-first byte assembly and SE0-based EOP detection.
// Ports:
//   clk, n_rst                 - clock (8 per bit), async active-low reset
//   d_plus_sync, d_minus_sync  - synchronized line inputs
//   rcv_en                     - low clears decode state (rcv_byte holds)
//   sample_en                  - mid-bit sample strobe
//   rcv_byte, byte_ready       - completed byte and its strobe
//   eop, stuff_err             - end-of-packet and stuff-violation strobes
module rx_bit_sampler
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       rcv_en,
    output logic       sample_en,
    output logic [7:0] rcv_byte,
    output logic       byte_ready,
    output logic       eop,
    output logic       stuff_err
);

    logic [1:0] se0_cnt, se0_cnt_n;
    logic       nrzi_prev, nrzi_prev_n;
    logic [2:0] ones, ones_n;
    logic [2:0] bitcnt, bitcnt_n;
    byte_t      shreg, shreg_n;
    byte_t      rcv_byte_n;
    logic       byte_ready_n, eop_n, stuff_err_n;
    logic       is_se0;
    logic       dbit;

    rx_bit_timer u_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_plus_sync (d_plus_sync),
        .rcv_en      (rcv_en),
        .sample_en   (sample_en)
    );

    assign is_se0 = !d_plus_sync && !d_minus_sync;
    // NRZI: no transition decodes as 1.
    assign dbit   = (d_plus_sync == nrzi_prev);

    always_comb begin
        se0_cnt_n    = se0_cnt;
        nrzi_prev_n  = nrzi_prev;
        ones_n       = ones;
        bitcnt_n     = bitcnt;
        shreg_n      = shreg;
        rcv_byte_n   = rcv_byte;
        byte_ready_n = 1'b0;
        eop_n        = 1'b0;
        stuff_err_n  = 1'b0;
        if (!rcv_en) begin
            se0_cnt_n   = 2'd0;
            nrzi_prev_n = 1'b1;
            ones_n      = 3'd0;
            bitcnt_n    = 3'd0;
        end else if (sample_en) begin
            if (is_se0) begin
                // SE0 leaves NRZI/stuff/bit state alone until EOP.
                if (se0_cnt == 2'(EOP_SE0_SAMPLES - 1)) begin
                    eop_n       = 1'b1;
                    se0_cnt_n   = 2'd0;
                    bitcnt_n    = 3'd0;
                    ones_n      = 3'd0;
                    nrzi_prev_n = 1'b1;
                    shreg_n     = '0;
                end else begin
                    se0_cnt_n = se0_cnt + 2'd1;
                end
            end else begin
                se0_cnt_n   = 2'd0;
                nrzi_prev_n = d_plus_sync;
                if (ones == 3'(STUFF_LIMIT)) begin
                    // Bit after six ones is dropped; a 1 here is illegal.
                    ones_n = 3'd0;
                    if (dbit) begin
                        stuff_err_n = 1'b1;
                        bitcnt_n    = 3'd0;
                    end
                end else begin
                    ones_n   = dbit ? ones + 3'd1 : 3'd0;
                    shreg_n  = {dbit, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        rcv_byte_n   = {dbit, shreg[7:1]};
                        byte_ready_n = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            se0_cnt    <= 2'd0;
            nrzi_prev  <= 1'b1;
            ones       <= 3'd0;
            bitcnt     <= 3'd0;
            shreg      <= '0;
            rcv_byte   <= 8'h00;
            byte_ready <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            se0_cnt    <= se0_cnt_n;
            nrzi_prev  <= nrzi_prev_n;
            ones       <= ones_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            rcv_byte   <= rcv_byte_n;
            byte_ready <= byte_ready_n;
            eop        <= eop_n;
            stuff_err  <= stuff_err_n;
        end
    end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Scoreboard bench for rx_bit_sampler: directed NRZI line stimulus,
// expected strobes queued and matched by an independent monitor.
module tb_rx_bit_sampler;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       d_plus_sync = 1'b1;
    logic       d_minus_sync = 1'b0;
    logic       rcv_en = 1'b0;
    logic       sample_en;
    logic [7:0] rcv_byte;
    logic       byte_ready;
    logic       eop;
    logic       stuff_err;

    rx_bit_sampler dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .rcv_en       (rcv_en),
        .sample_en    (sample_en),
        .rcv_byte     (rcv_byte),
        .byte_ready   (byte_ready),
        .eop          (eop),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;
    int last_samp = -100;
    int samp_q[$];
    // {kind, data}: kind 1 = byte, 2 = eop, 3 = stuff_err
    logic [9:0] exp_q[$];
    logic lvl = 1'b1;

    localparam logic [1:0] K_BYTE = 2'd1;
    localparam logic [1:0] K_EOP  = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] e;
        if (byte_ready || eop || stuff_err) begin
            got = {byte_ready ? K_BYTE : (eop ? K_EOP : K_ERR),
                   byte_ready ? rcv_byte : 8'h00};
            chk("strobe_latency", last_samp, cyc - 1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%0h required=none",
                         got);
            end else begin
                e = exp_q.pop_front();
                chk("event", int'(got), int'(e));
            end
        end
        if (sample_en) begin
            samp_q.push_back(cyc);
            last_samp = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic dp, input logic dm);
        d_plus_sync  = dp;
        d_minus_sync = dm;
        repeat (8) tick();
    endtask

    task automatic nbit(input logic b);
        if (!b) lvl = ~lvl;
        sym(lvl, ~lvl);
    endtask

    task automatic nbyte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) nbit(v[i]);
    endtask

    task automatic idle_off();
        rcv_en       = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        lvl          = 1'b1;
        repeat (4) tick();
        samp_q.delete();
    endtask

    task automatic start();
        rcv_en = 1'b1;
        e0     = cyc;
    endtask

    task automatic sb_empty(input string nm);
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        #2 n_rst = 1'b0;
        repeat (2) tick();
        chk("rst_rcv_byte", rcv_byte, 8'h00);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_eop", eop, 0);
        chk("rst_stuff_err", stuff_err, 0);
        chk("rst_sample_en", sample_en, 0);
        n_rst = 1'b1;
        idle_off();

        // Idle J: all ones, violation on the 7th sample.
        start();
        exp_q.push_back({K_ERR, 8'h00});
        repeat (56) tick();
        chk("idle_nsamp", samp_q.size(), 7);
        if (samp_q.size() >= 7) begin
            chk("idle_first", samp_q[0] - e0, 4);
            chk("idle_period", samp_q[1] - samp_q[0], 8);
            chk("idle_last", samp_q[6] - e0, 52);
        end
        sb_empty("idle_sb");
        idle_off();

        // SYNC (KJKJKJKK) then A5.
        start();
        exp_q.push_back({K_BYTE, 8'h80});
        exp_q.push_back({K_BYTE, 8'hA5});
        nbyte(8'h80);
        nbyte(8'hA5);
        chk("sync_nsamp", samp_q.size(), 16);
        sb_empty("sync_sb");
        idle_off();

        // FF with a stuffed zero after six ones.
        start();
        exp_q.push_back({K_BYTE, 8'hFF});
        repeat (6) nbit(1'b1);
        nbit(1'b0);
        nbit(1'b1);
        nbit(1'b1);
        chk("ff_nsamp", samp_q.size(), 9);
        sb_empty("ff_sb");
        idle_off();

        // Seven ones: violation, then a clean byte from bit 0.
        start();
        exp_q.push_back({K_ERR, 8'h00});
        exp_q.push_back({K_BYTE, 8'h3C});
        repeat (7) nbit(1'b1);
        nbyte(8'h3C);
        sb_empty("err_sb");
        idle_off();

        // Partial byte, EOP, then a fresh byte.
        start();
        exp_q.push_back({K_EOP, 8'h00});
        exp_q.push_back({K_BYTE, 8'h5A});
        nbit(1'b1);
        nbit(1'b0);
        nbit(1'b1);
        sym(1'b0, 1'b0);
        sym(1'b0, 1'b0);
        lvl = 1'b1;
        nbyte(8'h5A);
        sb_empty("eop_sb");
        chk("eop_rcv_byte", rcv_byte, 8'h5A);
        idle_off();

        // Resync: edge at count 6, edge at count 4, edge at count 8.
        start();
        d_plus_sync = 1'b0; d_minus_sync = 1'b1;
        repeat (6) tick();
        d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        repeat (4) tick();
        d_plus_sync = 1'b0; d_minus_sync = 1'b1;
        repeat (8) tick();
        d_plus_sync = 1'b1; d_minus_sync = 1'b0;
        repeat (6) tick();
        chk("sync_edge_nsamp", samp_q.size(), 4);
        if (samp_q.size() >= 4) begin
            chk("edge_s0", samp_q[0] - e0, 4);
            chk("edge_early", samp_q[1] - e0, 10);
            chk("edge_at_sample", samp_q[2] - e0, 14);
            chk("edge_at_wrap", samp_q[3] - e0, 22);
        end
        sb_empty("edge_sb");
        idle_off();

        // rcv_en dropped mid-byte.
        start();
        nbit(1'b1);
        nbit(1'b0);
        nbit(1'b1);
        rcv_en = 1'b0;
        repeat (8) tick();
        chk("drop_nsamp", samp_q.size(), 3);
        chk("drop_rcv_byte", rcv_byte, 8'h5A);
        idle_off();
        start();
        exp_q.push_back({K_BYTE, 8'hC3});
        nbyte(8'hC3);
        sb_empty("drop_sb");
        chk("drop_rcv_byte2", rcv_byte, 8'hC3);
        idle_off();

        // Async reset mid-byte.
        start();
        nbit(1'b0);
        nbit(1'b1);
        repeat (2) tick();
        #2 n_rst = 1'b0;
        #1;
        chk("arst_rcv_byte", rcv_byte, 8'h00);
        chk("arst_sample_en", sample_en, 0);
        chk("arst_strobes", {byte_ready, eop, stuff_err}, 0);
        rcv_en = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        idle_off();
        sb_empty("final_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
